// File: rtl/bus_arbiter.sv
// Two-master system-bus arbiter: registered IDLE/GNT_M0/GNT_M1 FSM plus owner mux.
// Define BUS_ARB_TIMEOUT_EN to build the grant hold-limit counter (MAX_HOLD cycles).
module bus_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int RR_EN    = 0,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_wr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_wr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic              m_req,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_wr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              arb_timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M0 = 2'd1,
    GNT_M1 = 2'd2
  } state_t;

  state_t state;
  state_t nxt;
  logic   last_m1;  // 1: master 1 was granted most recently

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int              CNT_W   = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             hold_sat;
  logic             tmo_nxt;

  assign hold_sat = (hold_cnt == CNT_MAX);
`endif

  always_comb begin
    nxt = state;
`ifdef BUS_ARB_TIMEOUT_EN
    tmo_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (m0_req && m1_req)
          nxt = ((RR_EN != 0) && !last_m1) ? GNT_M1 : GNT_M0;
        else if (m0_req)
          nxt = GNT_M0;
        else if (m1_req)
          nxt = GNT_M1;
      end
      GNT_M0: begin
        if (!m0_req)
          nxt = m1_req ? GNT_M1 : IDLE;
`ifdef BUS_ARB_TIMEOUT_EN
        else if (hold_sat && m1_req) begin
          nxt     = GNT_M1;
          tmo_nxt = 1'b1;
        end
`endif
      end
      GNT_M1: begin
        if (!m1_req)
          nxt = m0_req ? GNT_M0 : IDLE;
`ifdef BUS_ARB_TIMEOUT_EN
        else if (hold_sat && m0_req) begin
          nxt     = GNT_M0;
          tmo_nxt = 1'b1;
        end
`endif
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      m0_grant <= 1'b0;
      m1_grant <= 1'b0;
      last_m1  <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_cnt    <= '0;
      arb_timeout <= 1'b0;
`endif
    end else begin
      state    <= nxt;
      m0_grant <= (nxt == GNT_M0);
      m1_grant <= (nxt == GNT_M1);
      if (nxt == GNT_M0)
        last_m1 <= 1'b0;
      else if (nxt == GNT_M1)
        last_m1 <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
      arb_timeout <= tmo_nxt;
      if (nxt != state)
        hold_cnt <= '0;
      else if (state != IDLE && !hold_sat)
        hold_cnt <= hold_cnt + 1'b1;
`endif
    end
  end

`ifndef BUS_ARB_TIMEOUT_EN
  assign arb_timeout = 1'b0;
`endif

  // Owner mux follows the live request so m_req drops the cycle the owner releases.
  always_comb begin
    m_req   = 1'b0;
    m_addr  = '0;
    m_wr    = 1'b0;
    m_wdata = '0;
    case (state)
      GNT_M0: begin
        m_req   = m0_req;
        m_addr  = m0_addr;
        m_wr    = m0_wr;
        m_wdata = m0_wdata;
      end
      GNT_M1: begin
        m_req   = m1_req;
        m_addr  = m1_addr;
        m_wr    = m1_wr;
        m_wdata = m1_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: fixed-priority and round-robin instances
// driven in parallel with hand-derived expected owners queued per cycle.
module tb_bus_arbiter;

  localparam logic [15:0] A0 = 16'h1234;
  localparam logic [31:0] D0 = 32'hA0A0_0001;
  localparam logic [15:0] A1 = 16'h7010;
  localparam logic [31:0] D1 = 32'hB1B1_0002;
  localparam int N  = 0;
  localparam int M0 = 1;
  localparam int M1 = 2;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TMO_B = 1'b1;
`else
  localparam bit TMO_B = 1'b0;
`endif
  localparam int SW = TMO_B ? M1 : M0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        m0_req, m1_req;
  logic [15:0] m0_addr, m1_addr;
  logic        m0_wr, m1_wr;
  logic [31:0] m0_wdata, m1_wdata;

  logic        fp_g0, fp_g1, fp_mreq, fp_mwr, fp_tmo;
  logic [15:0] fp_maddr;
  logic [31:0] fp_mwdata;
  logic        rr_g0, rr_g1, rr_mreq, rr_mwr, rr_tmo;
  logic [15:0] rr_maddr;
  logic [31:0] rr_mwdata;

  bus_arbiter #(.ADDR_W(16), .DATA_W(32), .RR_EN(0), .MAX_HOLD(4)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wr(m0_wr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wr(m1_wr), .m1_wdata(m1_wdata),
    .m0_grant(fp_g0), .m1_grant(fp_g1), .m_req(fp_mreq), .m_addr(fp_maddr),
    .m_wr(fp_mwr), .m_wdata(fp_mwdata), .arb_timeout(fp_tmo)
  );

  bus_arbiter #(.ADDR_W(16), .DATA_W(32), .RR_EN(1), .MAX_HOLD(4)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wr(m0_wr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wr(m1_wr), .m1_wdata(m1_wdata),
    .m0_grant(rr_g0), .m1_grant(rr_g1), .m_req(rr_mreq), .m_addr(rr_maddr),
    .m_wr(rr_mwr), .m_wdata(rr_mwdata), .arb_timeout(rr_tmo)
  );

  logic [52:0] obs_fp, obs_rr;
  assign obs_fp = {fp_tmo, fp_g0, fp_g1, fp_mreq, fp_mwr, fp_maddr, fp_mwdata};
  assign obs_rr = {rr_tmo, rr_g0, rr_g1, rr_mreq, rr_mwr, rr_maddr, rr_mwdata};

  typedef struct packed {
    logic [52:0] fp;
    logic [52:0] rr;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [52:0] pk(input int owner, input bit tmo);
    case (owner)
      M0:      return {tmo, 1'b1, 1'b0, 1'b1, 1'b1, A0, D0};
      M1:      return {tmo, 1'b0, 1'b1, 1'b1, 1'b0, A1, D1};
      default: return {tmo, 4'b0000, 16'h0000, 32'h0000_0000};
    endcase
  endfunction

  // Drive one cycle of requests, queue the expected post-edge outputs, then score them.
  task automatic cyc(input bit r0, input bit r1, input int o_fp, input int o_rr, input bit tmo);
    exp_t e;
    m0_req = r0;
    m1_req = r1;
    e.fp = pk(o_fp, tmo);
    e.rr = pk(o_rr, tmo);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    step++;
    chk($sformatf("fp_step%0d", step), 64'(obs_fp), 64'(e.fp));
    chk($sformatf("rr_step%0d", step), 64'(obs_rr), 64'(e.rr));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    m0_req   = 1'b0;
    m1_req   = 1'b0;
    m0_addr  = A0;
    m0_wr    = 1'b1;
    m0_wdata = D0;
    m1_addr  = A1;
    m1_wr    = 1'b0;
    m1_wdata = D1;

    // requests while in reset are ignored
    cyc(1, 1, N, N, 0);
    cyc(1, 1, N, N, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) cyc(0, 0, N, N, 0);

    cyc(0, 1, M1, M1, 0);
    cyc(0, 1, M1, M1, 0);
    m1_req = 1'b0;
    #1;
    chk("drop_mreq_fp", 64'(fp_mreq), 64'(0));
    chk("drop_grant_fp", 64'(fp_g1), 64'(1));
    chk("drop_mreq_rr", 64'(rr_mreq), 64'(0));
    cyc(0, 0, N, N, 0);

    // tie then direct handover, no idle bubble
    cyc(1, 1, M0, M0, 0);
    cyc(0, 1, M1, M1, 0);
    cyc(0, 0, N, N, 0);

    // three tie arbitrations
    cyc(1, 1, M0, M0, 0);
    cyc(0, 0, N, N, 0);
    cyc(1, 1, M0, M1, 0);
    cyc(0, 0, N, N, 0);
    cyc(1, 1, M0, M0, 0);
    cyc(0, 0, N, N, 0);

    // no preemption below the hold limit
    cyc(1, 0, M0, M0, 0);
    cyc(1, 1, M0, M0, 0);
    cyc(1, 1, M0, M0, 0);
    cyc(0, 1, M1, M1, 0);
    cyc(0, 0, N, N, 0);

    // hold limit with contention
    cyc(1, 0, M0, M0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, M0, M0, 0);
    cyc(1, 1, SW, SW, TMO_B);
    cyc(1, 1, SW, SW, 0);
    cyc(0, 0, N, N, 0);

    // saturated counter, then a late competing request
    for (int i = 0; i < 6; i++) cyc(1, 0, M0, M0, 0);
    cyc(1, 1, SW, SW, TMO_B);
    cyc(0, 0, N, N, 0);

    // async reset mid-grant
    cyc(1, 0, M0, M0, 0);
    reset_n = 1'b0;
    #1;
    chk("async_rst_fp", 64'(obs_fp), 64'(pk(N, 0)));
    chk("async_rst_rr", 64'(obs_rr), 64'(pk(N, 0)));
    cyc(1, 0, N, N, 0);
    reset_n = 1'b1;
    cyc(0, 0, N, N, 0);
    cyc(1, 1, M0, M0, 0);
    cyc(0, 0, N, N, 0);

    chk("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
